// File: rtl/fact_pkg.sv
// Shared types and elaboration helpers for the iterative factorial engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fact_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } fact_state_t;

    // Default datapath width and the matching "multiplicative identity" pattern.
    localparam int FACT_DEF_WIDTH = 32;
    localparam logic [FACT_DEF_WIDTH-1:0] ONE = {{(FACT_DEF_WIDTH-1){1'b0}}, 1'b1};

    // Largest n whose n! still fits in an unsigned register of the given width.
    function automatic int fact_max_n(input int width);
        longint unsigned p;
        int              m;
        bit              stop;
        p    = 64'd1;
        m    = 0;
        stop = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (!stop) begin
                if (width < 64 && (p * longint'(k)) >= (64'd1 << width)) begin
                    stop = 1'b1;
                end else begin
                    p = p * longint'(k);
                    m = k;
                end
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/fact_down_counter.sv
// Loadable down counter holding the remaining multiplier; gt1 flags work left.
// Latency: load/decrement visible one clock after ld/en; gt1 is decoded from the register.
// Backpressure: none; ld has priority over en.
module fact_down_counter #(
    parameter int N_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ld,
    input  logic               en,
    input  logic [N_WIDTH-1:0] d,
    output logic [N_WIDTH-1:0] q,
    output logic               gt1
);

    // Load the operand on acceptance, otherwise step down once per multiply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end else if (en) begin
            q <= q - 1'b1;
        end
    end

    assign gt1 = (q > {{(N_WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/factorial_engine.sv
// Iterative n! engine, one multiply per clock, go/busy/done/err handshake.
// Latency: done rises max(n,1) clocks after the accepting edge; rejects answer in one clock.
// Backpressure: go is only sampled in IDLE; requests during a run are dropped. Optional macro FACT_OVF_DETECT_EN aborts on product overflow.
module factorial_engine
    import fact_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int N_WIDTH = 4,
    parameter int MAX_N   = fact_max_n(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               go,
    input  logic [N_WIDTH-1:0] n,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [WIDTH-1:0]   result
);

    localparam logic [WIDTH-1:0] PROD_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam int unsigned      MAX_N_U  = MAX_N;

    fact_state_t        state, state_nxt;
    logic [WIDTH-1:0]   prod, prod_nxt;
    logic [WIDTH-1:0]   result_nxt;
    logic               busy_nxt, done_nxt, err_nxt;
    logic               cnt_ld, cnt_en, cnt_gt1;
    logic [N_WIDTH-1:0] cnt;
    logic               in_range;
    logic [WIDTH-1:0]   mul_lo;

    assign in_range = (32'(n) <= MAX_N_U);

`ifdef FACT_OVF_DETECT_EN
    logic [WIDTH+N_WIDTH-1:0] mul_full;
    logic                     mul_ovf;
    assign mul_full = {{N_WIDTH{1'b0}}, prod} * {{WIDTH{1'b0}}, cnt};
    assign mul_lo   = mul_full[WIDTH-1:0];
    assign mul_ovf  = |mul_full[WIDTH+N_WIDTH-1:WIDTH];
`else
    // Only the low WIDTH bits are kept, so the product wraps modulo 2^WIDTH.
    assign mul_lo = prod * {{(WIDTH-N_WIDTH){1'b0}}, cnt};
`endif

    fact_down_counter #(
        .N_WIDTH (N_WIDTH)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (cnt_ld),
        .en    (cnt_en),
        .d     (n),
        .q     (cnt),
        .gt1   (cnt_gt1)
    );

    // Next-state and next-output decode; everything holds unless a transition says otherwise.
    always_comb begin
        state_nxt  = state;
        prod_nxt   = prod;
        result_nxt = result;
        busy_nxt   = busy;
        done_nxt   = done;
        err_nxt    = err;
        cnt_ld     = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    if (in_range) begin
                        cnt_ld    = 1'b1;
                        prod_nxt  = PROD_ONE;
                        busy_nxt  = 1'b1;
                        done_nxt  = 1'b0;
                        err_nxt   = 1'b0;
                        state_nxt = MUL;
                    end else begin
                        err_nxt  = 1'b1;
                        done_nxt = 1'b1;
                    end
                end
            end
            MUL: begin
                if (cnt_gt1) begin
`ifdef FACT_OVF_DETECT_EN
                    if (mul_ovf) begin
                        err_nxt   = 1'b1;
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        prod_nxt = mul_lo;
                        cnt_en   = 1'b1;
                    end
`else
                    prod_nxt = mul_lo;
                    cnt_en   = 1'b1;
`endif
                end else begin
                    // cnt of 0 or 1 means the product is complete (also covers 0! and 1!).
                    result_nxt = prod;
                    done_nxt   = 1'b1;
                    busy_nxt   = 1'b0;
                    state_nxt  = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, product and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            prod   <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            prod   <= prod_nxt;
            result <= result_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
            err    <= err_nxt;
        end
    end

endmodule

// File: tb/tb_factorial_engine.sv
// Self-checking bench: a 32-bit default engine plus a 16-bit, MAX_N=15 engine for wrap/overflow runs.
// Latency: measured per request in clock edges after the accepting edge.
// Backpressure: go is driven on the falling edge, outputs sampled 1 time unit after the rising edge.
module tb_factorial_engine;

`ifdef FACT_OVF_DETECT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        go32, go16;
    logic [3:0]  n32, n16;
    logic        busy32, done32, err32;
    logic        busy16, done16, err16;
    logic [31:0] result32;
    logic [15:0] result16;

    int checks;
    int errors;
    longint unsigned exp32;
    longint unsigned exp16;

    factorial_engine #(.WIDTH(32), .N_WIDTH(4), .MAX_N(12)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .go     (go32),
        .n      (n32),
        .busy   (busy32),
        .done   (done32),
        .err    (err32),
        .result (result32)
    );

    factorial_engine #(.WIDTH(16), .N_WIDTH(4), .MAX_N(15)) dut16 (
        .clk    (clk),
        .rst_n  (rst_n),
        .go     (go16),
        .n      (n16),
        .busy   (busy16),
        .done   (done16),
        .err    (err16),
        .result (result16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact n! with plain integer arithmetic. With overflow detection, the run stops
    // on the first partial product that no longer fits, after (n-k+1) steps.
    function automatic void ref_fact(input int w, input int nv, output longint unsigned res,
                                     output bit ovf, output int lat);
        longint unsigned exact;
        exact = 64'd1;
        ovf   = 1'b0;
        lat   = (nv < 1) ? 1 : nv;
        for (int k = nv; k >= 2; k--) begin
            if (OVF_EN && (exact * longint'(k)) >= (64'd1 << w)) begin
                ovf = 1'b1;
                lat = nv - k + 1;
                break;
            end
            exact = exact * longint'(k);
        end
        res = exact & ((64'd1 << w) - 64'd1);
    endfunction

    // Issue one go pulse and count edges until done; busy_lo counts busy-low samples while waiting.
    task automatic do_req(input bit sel, input int nv, output int lat, output int busy_lo);
        @(negedge clk);
        if (sel) begin go16 = 1'b1; n16 = 4'(nv); end
        else     begin go32 = 1'b1; n32 = 4'(nv); end
        @(posedge clk);
        #1;
        go16 = 1'b0;
        go32 = 1'b0;
        lat = 0;
        busy_lo = 0;
        while (!(sel ? done16 : done32) && lat < 64) begin
            if (!(sel ? busy16 : busy32)) busy_lo++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        go32 = 1'b0; go16 = 1'b0; n32 = '0; n16 = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy32, done32, err32, result32} !== 35'd0) begin
            errors++;
            $display("FAIL reset32: got busy=%b done=%b err=%b result=%0d, want all 0", busy32, done32, err32, result32);
        end
        checks++;
        if ({busy16, done16, err16, result16} !== 19'd0) begin
            errors++;
            $display("FAIL reset16: got busy=%b done=%b err=%b result=%0d, want all 0", busy16, done16, err16, result16);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp32 = 0;
        exp16 = 0;
    endtask

    task automatic test_reset_mid_run();
        int lat, bl;
        do_req(0, 5, lat, bl);
        exp32 = 120;
        @(negedge clk);
        go32 = 1'b1; n32 = 4'd7;
        @(posedge clk);
        #1;
        go32 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy32, done32, err32, result32} !== 35'd0) begin
            errors++;
            $display("FAIL reset_mid_run: got busy=%b done=%b err=%b result=%0d, want all 0", busy32, done32, err32, result32);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp32 = 0;
        exp16 = 0;
        do_req(0, 3, lat, bl);
        checks++;
        if (result32 !== 32'd6 || lat != 3) begin
            errors++;
            $display("FAIL after_reset_n3: got result=%0d lat=%0d, want 6 lat=3", result32, lat);
        end
        exp32 = 6;
    endtask

    task automatic test_nominal();
        int lat, bl;
        do_req(0, 5, lat, bl);
        checks++;
        if (result32 !== 32'd120 || lat != 5 || bl != 0 || err32 !== 1'b0 || busy32 !== 1'b0) begin
            errors++;
            $display("FAIL nominal_n5: got result=%0d lat=%0d busy_lo=%0d err=%b busy=%b, want 120 lat=5 busy_lo=0 err=0 busy=0",
                     result32, lat, bl, err32, busy32);
        end
        do_req(0, 12, lat, bl);
        checks++;
        if (result32 !== 32'd479001600 || lat != 12 || bl != 0 || err32 !== 1'b0) begin
            errors++;
            $display("FAIL nominal_n12: got result=%0d lat=%0d busy_lo=%0d err=%b, want 479001600 lat=12 busy_lo=0 err=0",
                     result32, lat, bl, err32);
        end
        exp32 = 479001600;
    endtask

    task automatic test_boundary();
        int lat, bl;
        for (int nv = 0; nv <= 1; nv++) begin
            do_req(0, nv, lat, bl);
            checks++;
            if (result32 !== 32'd1 || lat != 1 || err32 !== 1'b0 || done32 !== 1'b1) begin
                errors++;
                $display("FAIL boundary_n%0d: got result=%0d lat=%0d err=%b done=%b, want 1 lat=1 err=0 done=1",
                         nv, result32, lat, err32, done32);
            end
        end
        exp32 = 1;
    endtask

    task automatic test_reject();
        int lat, bl;
        int busy_seen;
        do_req(0, 5, lat, bl);
        exp32 = 120;
        do_req(0, 13, lat, bl);
        checks++;
        if (lat != 0 || err32 !== 1'b1 || done32 !== 1'b1 || busy32 !== 1'b0 || result32 !== 32'd120) begin
            errors++;
            $display("FAIL reject_n13: got lat=%0d err=%b done=%b busy=%b result=%0d, want lat=0 err=1 done=1 busy=0 result=120",
                     lat, err32, done32, busy32, result32);
        end
        busy_seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (busy32) busy_seen++;
        end
        checks++;
        if (busy_seen != 0 || result32 !== 32'd120) begin
            errors++;
            $display("FAIL reject_hold: got busy_cycles=%0d result=%0d, want 0 and 120", busy_seen, result32);
        end
    endtask

    task automatic test_busy_ignore();
        int t;
        @(negedge clk);
        go32 = 1'b1; n32 = 4'd4;
        @(negedge clk);
        n32 = 4'd9;
        @(negedge clk);
        go32 = 1'b0;
        t = 0;
        while (!done32 && t < 64) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (result32 !== 32'd24 || err32 !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore: got result=%0d err=%b, want 24 err=0", result32, err32);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy32 !== 1'b0 || done32 !== 1'b1 || result32 !== 32'd24) begin
            errors++;
            $display("FAIL busy_ignore_no_queue: got busy=%b done=%b result=%0d, want busy=0 done=1 result=24",
                     busy32, done32, result32);
        end
        exp32 = 24;
    endtask

    task automatic test_back_to_back();
        int t;
        @(negedge clk);
        go32 = 1'b1; n32 = 4'd3;
        t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (!done32 && t < 64);
        checks++;
        if (result32 !== 32'd6 || t != 4) begin
            errors++;
            $display("FAIL b2b_first: got result=%0d edges=%0d, want 6 edges=4", result32, t);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done32 !== 1'b0 || busy32 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_retrigger: got done=%b busy=%b, want done=0 busy=1", done32, busy32);
        end
        go32 = 1'b0;
        t = 0;
        while (!done32 && t < 64) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (result32 !== 32'd6 || t != 3 || err32 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got result=%0d lat=%0d err=%b, want 6 lat=3 err=0", result32, t, err32);
        end
        exp32 = 6;
    endtask

    task automatic test_random32();
        int lat, bl, nv, elat;
        longint unsigned eres;
        bit eovf;
        for (int i = 0; i < 20; i++) begin
            nv = int'($urandom_range(0, 15));
            do_req(0, nv, lat, bl);
            checks++;
            if (nv > 12) begin
                if (lat != 0 || err32 !== 1'b1 || done32 !== 1'b1 || result32 !== exp32[31:0]) begin
                    errors++;
                    $display("FAIL random32_reject n=%0d: got lat=%0d err=%b done=%b result=%0d, want lat=0 err=1 done=1 result=%0d",
                             nv, lat, err32, done32, result32, exp32);
                end
            end else begin
                ref_fact(32, nv, eres, eovf, elat);
                exp32 = eres;
                if (lat != elat || bl != 0 || err32 !== 1'b0 || result32 !== exp32[31:0]) begin
                    errors++;
                    $display("FAIL random32 n=%0d: got lat=%0d busy_lo=%0d err=%b result=%0d, want lat=%0d busy_lo=0 err=0 result=%0d",
                             nv, lat, bl, err32, result32, elat, exp32);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int lat, bl, nv, elat;
        longint unsigned eres;
        bit eovf;
        do_req(1, 5, lat, bl);
        checks++;
        if (result16 !== 16'd120 || lat != 5 || err16 !== 1'b0) begin
            errors++;
            $display("FAIL w16_n5: got result=%0d lat=%0d err=%b, want 120 lat=5 err=0", result16, lat, err16);
        end
        exp16 = 120;
        for (int i = 0; i < 13; i++) begin
            nv = (i == 0) ? 9 : int'($urandom_range(0, 15));
            ref_fact(16, nv, eres, eovf, elat);
            if (!eovf) exp16 = eres;
            do_req(1, nv, lat, bl);
            checks++;
            if (lat != elat || err16 !== eovf || done16 !== 1'b1 || busy16 !== 1'b0 || result16 !== exp16[15:0]) begin
                errors++;
                $display("FAIL w16 n=%0d: got lat=%0d err=%b done=%b busy=%b result=%0d, want lat=%0d err=%b done=1 busy=0 result=%0d",
                         nv, lat, err16, done16, busy16, result16, elat, eovf, exp16);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_reset_mid_run();
        test_nominal();
        test_boundary();
        test_reject();
        test_busy_ignore();
        test_back_to_back();
        test_random32();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
